// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder.
// FSM state encoding plus the ASCII control codes used for CR/LF expansion.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_ACT,
    WAIT_DONE,
    HOLDOFF
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO: storage, wrapping pointers, occupancy count, full/empty.
// Reads are fall-through: rd_data always shows the head entry.
module sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LIMIT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH; count tracks push/pop balance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue and launch FSM in front of the serial transmitter.
// Define UART_TX_FEEDER_CRLF_EN to expand each queued LF into CR then LF.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  input  logic            i_Wr_En,
  input  logic [7:0]      i_Wr_Byte,
  output logic            o_Ready,
  output logic            o_Overflow,
  input  logic            i_Clr_Overflow,
  output logic [ADDR_W:0] o_Count,
  output logic            o_Busy,
  output logic            o_Tx_DV,
  output logic [7:0]      o_Tx_Byte,
  input  logic            i_Tx_Active,
  input  logic            i_Tx_Done
);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  byte_nxt;
  logic [7:0]  rd_data;
  logic        pop;
  logic        full;
  logic        empty;
`ifdef UART_TX_FEEDER_CRLF_EN
  logic        lf_pend;
  logic        lf_nxt;
`endif

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock   (i_Clock),
    .reset   (i_Reset),
    .push    (i_Wr_En),
    .pop     (pop),
    .wr_data (i_Wr_Byte),
    .rd_data (rd_data),
    .count   (o_Count),
    .full    (full),
    .empty   (empty)
  );

  assign o_Ready = !full;
  assign o_Tx_DV = (state == LAUNCH);
`ifdef UART_TX_FEEDER_CRLF_EN
  assign o_Busy  = !empty || (state != IDLE) || lf_pend;
`else
  assign o_Busy  = !empty || (state != IDLE);
`endif

  // Sticky overflow; an explicit clear wins over a same-cycle drop.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset)             o_Overflow <= 1'b0;
    else if (i_Clr_Overflow) o_Overflow <= 1'b0;
    else if (i_Wr_En && full) o_Overflow <= 1'b1;
  end

  // FSM state, launched byte and pending-LF flag.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state     <= IDLE;
      o_Tx_Byte <= 8'h00;
`ifdef UART_TX_FEEDER_CRLF_EN
      lf_pend   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      o_Tx_Byte <= byte_nxt;
`ifdef UART_TX_FEEDER_CRLF_EN
      lf_pend   <= lf_nxt;
`endif
    end
  end

  // Launch sequencing: pop, pulse DV, then track the frame to completion.
  always_comb begin
    state_nxt = state;
    byte_nxt  = o_Tx_Byte;
    pop       = 1'b0;
`ifdef UART_TX_FEEDER_CRLF_EN
    lf_nxt    = lf_pend;
`endif
    unique case (state)
      IDLE: begin
`ifdef UART_TX_FEEDER_CRLF_EN
        if (lf_pend) begin
          byte_nxt  = ASCII_LF;
          lf_nxt    = 1'b0;
          state_nxt = LAUNCH;
        end else if (!empty) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
          if (rd_data == ASCII_LF) begin
            byte_nxt = ASCII_CR;
            lf_nxt   = 1'b1;
          end else begin
            byte_nxt = rd_data;
          end
        end
`else
        if (!empty) begin
          pop       = 1'b1;
          byte_nxt  = rd_data;
          state_nxt = LAUNCH;
        end
`endif
      end
      LAUNCH:    state_nxt = WAIT_ACT;
      WAIT_ACT:  if (i_Tx_Active) state_nxt = WAIT_DONE;
      WAIT_DONE: if (i_Tx_Done) state_nxt = HOLDOFF;
      HOLDOFF:   if (!i_Tx_Done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder with a behavioural transmitter.
// Honours UART_TX_FEEDER_CRLF_EN when building expected launch sequences.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       i_Reset;
  logic       i_Wr_En;
  logic [7:0] i_Wr_Byte;
  logic       o_Ready;
  logic       o_Overflow;
  logic       i_Clr_Overflow;
  logic [4:0] o_Count;
  logic       o_Busy;
  logic       o_Tx_DV;
  logic [7:0] o_Tx_Byte;
  logic       i_Tx_Active;
  logic       i_Tx_Done;

  int         vectors = 0;
  int         miscompares = 0;
  int         launches = 0;
  int         frames_done = 0;
  bit         stall = 1'b0;
  logic [7:0] exp_q [$];
  logic [7:0] last_byte = 8'h00;
  bit         last_valid = 1'b0;

  uart_tx_feeder #(.DEPTH(16)) dut (
    .i_Clock        (clk),
    .i_Reset        (i_Reset),
    .i_Wr_En        (i_Wr_En),
    .i_Wr_Byte      (i_Wr_Byte),
    .o_Ready        (o_Ready),
    .o_Overflow     (o_Overflow),
    .i_Clr_Overflow (i_Clr_Overflow),
    .o_Count        (o_Count),
    .o_Busy         (o_Busy),
    .o_Tx_DV        (o_Tx_DV),
    .o_Tx_Byte      (o_Tx_Byte),
    .i_Tx_Active    (i_Tx_Active),
    .i_Tx_Done      (i_Tx_Done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every launch pops the scoreboard; held byte checked mid-frame.
  always @(negedge clk) begin
    if (!i_Reset && o_Tx_DV) begin
      launches++;
      chk("dv_while_done", {31'd0, i_Tx_Done}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_launch", {24'd0, o_Tx_Byte}, 32'hFFFF_FFFF);
      end else begin
        last_byte  = exp_q.pop_front();
        last_valid = 1'b1;
        chk("tx_byte", {24'd0, o_Tx_Byte}, {24'd0, last_byte});
      end
    end else if (!i_Reset && last_valid && i_Tx_Active) begin
      chk("tx_byte_hold", {24'd0, o_Tx_Byte}, {24'd0, last_byte});
    end
  end

  // Transmitter model: 10 active cycles, then a 2-cycle done pulse.
  initial begin
    i_Tx_Active = 1'b0;
    i_Tx_Done   = 1'b0;
    forever begin
      @(posedge clk);
      if (launches > frames_done && !stall) begin
        #1 i_Tx_Active = 1'b1;
        repeat (10) @(posedge clk);
        #1 i_Tx_Active = 1'b0;
        i_Tx_Done = 1'b1;
        repeat (2) @(posedge clk);
        #1 i_Tx_Done = 1'b0;
        frames_done++;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    i_Wr_En   = 1'b1;
    i_Wr_Byte = b;
    if (o_Ready) begin
`ifdef UART_TX_FEEDER_CRLF_EN
      if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
      exp_q.push_back(b);
    end
    @(negedge clk);
    i_Wr_En = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (n < 3000 && !(!o_Busy && frames_done == launches &&
           !i_Tx_Active && !i_Tx_Done)) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle"}, {31'd0, o_Busy}, 32'd0);
  endtask

  task automatic wait_launch(input int target, input string nm);
    int n;
    n = 0;
    while (n < 200 && launches < target) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_launch"}, launches, target);
  endtask

  task automatic wait_done_lvl(input logic lvl, input string nm);
    int n;
    n = 0;
    while (n < 200 && i_Tx_Done !== lvl) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, i_Tx_Done}, {31'd0, lvl});
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_dv"},    {31'd0, o_Tx_DV},    32'd0);
    chk({nm, "_byte"},  {24'd0, o_Tx_Byte},  32'd0);
    chk({nm, "_ovf"},   {31'd0, o_Overflow}, 32'd0);
    chk({nm, "_count"}, {27'd0, o_Count},    32'd0);
    chk({nm, "_ready"}, {31'd0, o_Ready},    32'd1);
    chk({nm, "_busy"},  {31'd0, o_Busy},     32'd0);
  endtask

  initial begin
    int base;
    logic [7:0] hello [5];
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    i_Reset        = 1'b1;
    i_Wr_En        = 1'b0;
    i_Wr_Byte      = 8'h00;
    i_Clr_Overflow = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    i_Reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("post_rst");

    // Single byte: launch two edges after the push.
    base = launches;
    push(8'h41);
    chk("single_count", {27'd0, o_Count}, 32'd1);
    chk("single_dv_early", {31'd0, o_Tx_DV}, 32'd0);
    @(negedge clk);
    chk("single_dv", {31'd0, o_Tx_DV}, 32'd1);
    @(negedge clk);
    chk("single_dv_width", {31'd0, o_Tx_DV}, 32'd0);
    wait_idle("single");
    chk("single_nlaunch", launches - base, 32'd1);

    // Fill while the transmitter never goes active.
    stall = 1'b1;
    push(8'hEE);
    wait_launch(launches + 1, "fill_prime");
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("fill_count", {27'd0, o_Count}, 32'd16);
    chk("fill_ready", {31'd0, o_Ready}, 32'd0);
    push(8'hFF);
    chk("ovf_set", {31'd0, o_Overflow}, 32'd1);
    chk("ovf_count", {27'd0, o_Count}, 32'd16);
    i_Clr_Overflow = 1'b1;
    @(negedge clk);
    i_Clr_Overflow = 1'b0;
    chk("ovf_clr", {31'd0, o_Overflow}, 32'd0);
    i_Clr_Overflow = 1'b1;
    push(8'hFF);
    i_Clr_Overflow = 1'b0;
    chk("ovf_clr_prio", {31'd0, o_Overflow}, 32'd0);
    stall = 1'b0;
    wait_idle("fill");
    chk("fill_ready_after", {31'd0, o_Ready}, 32'd1);

    // Stream "HELLO", then 20 more bytes across the pointer wrap.
    base = launches;
    for (int i = 0; i < 5; i++) push(hello[i]);
    wait_idle("hello");
    chk("hello_nlaunch", launches - base, 32'd5);
    base = launches;
    for (int i = 0; i < 20; i++) begin
      push(8'h60 + 8'(i));
      repeat (7) @(negedge clk);
    end
    wait_idle("wrap");
    chk("wrap_nlaunch", launches - base, 32'd20);
    chk("wrap_ovf", {31'd0, o_Overflow}, 32'd0);

    // Push on the exact pop cycle with three queued.
    stall = 1'b1;
    push(8'h50);
    wait_launch(launches + 1, "pp_prime");
    push(8'h51);
    push(8'h52);
    push(8'h53);
    chk("pp_count3", {27'd0, o_Count}, 32'd3);
    stall = 1'b0;
    wait_done_lvl(1'b1, "pp_done_hi");
    wait_done_lvl(1'b0, "pp_done_lo");
    @(negedge clk);
    push(8'h54);
    chk("pp_count_same", {27'd0, o_Count}, 32'd3);
    chk("pp_dv", {31'd0, o_Tx_DV}, 32'd1);
    wait_idle("pp");

    // Reset in WAIT_DONE with four queued.
    push(8'h30);
    for (int i = 1; i < 5; i++) push(8'h30 + 8'(i));
    begin
      int n;
      n = 0;
      while (n < 100 && !i_Tx_Active) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    @(negedge clk);
    chk("mid_count4", {27'd0, o_Count}, 32'd4);
    i_Reset = 1'b1;
    exp_q.delete();
    last_valid = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    i_Reset = 1'b0;
    begin
      int n;
      n = 0;
      while (n < 100 && frames_done != launches) begin
        @(negedge clk);
        n++;
      end
      chk("mid_frame_end", frames_done, launches);
    end
    base = launches;
    push(8'h70);
    wait_idle("after_rst");
    chk("after_rst_nlaunch", launches - base, 32'd1);

    // LF handling.
    base = launches;
    push(8'h0A);
    push(8'h42);
    wait_idle("crlf");
`ifdef UART_TX_FEEDER_CRLF_EN
    chk("crlf_nlaunch", launches - base, 32'd3);
`else
    chk("crlf_nlaunch", launches - base, 32'd2);
`endif

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
